// File: rtl/moment_acc_pkg.sv
// moment_acc_pkg: shared FSM state type and saturation bounds for the moment accumulator.
package moment_acc_pkg;
  typedef enum logic {IDLE, ACCUM} state_e;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
endpackage

// File: rtl/moment_acc_ch.sv
// moment_acc_ch: one channel add (sign-extend term onto base); clamps when MOMENT_ACC_SAT_EN is defined.
module moment_acc_ch
  import moment_acc_pkg::*;
#(
  parameter int IN_W  = 23,
  parameter int ACC_W = 29
) (
  input  logic [ACC_W-1:0] base_i,
  input  logic [IN_W-1:0]  term_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);
  logic [ACC_W-1:0] ext, raw;
  assign ext = ACC_W'($signed(term_i));
  assign raw = base_i + ext;
`ifdef MOMENT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN = ACC_W'(sat_min(ACC_W));
  // Overflow only when both operands share a sign the result does not.
  assign ovf_o = (base_i[ACC_W-1] == ext[ACC_W-1]) & (raw[ACC_W-1] != base_i[ACC_W-1]);
  assign sum_o = ovf_o ? (base_i[ACC_W-1] ? MIN : MAX) : raw;
`else
  assign ovf_o = 1'b0;
  assign sum_o = raw;
`endif
endmodule

// File: rtl/moment_acc_multi.sv
// moment_acc_multi: multi-channel cluster moment accumulator with held result; MOMENT_ACC_SAT_EN enables clamping.
module moment_acc_multi
  import moment_acc_pkg::*;
#(
  parameter int NCH   = 5,
  parameter int IN_W  = 23,
  parameter int ACC_W = 29,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_first,
  input  logic                 s_last,
  input  logic [NCH*IN_W-1:0]  s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NCH*ACC_W-1:0] m_data,
  output logic [CNT_W-1:0]     m_count,
  output logic [NCH-1:0]       m_ovf,
  output logic                 err
);
  state_e state_q, state_d;
  logic [NCH*ACC_W-1:0] acc_q, acc_d, sum_w, m_data_q, m_data_d;
  logic [NCH-1:0] ovf_q, ovf_d, ovf_w, m_ovf_q, m_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, m_count_q, m_count_d;
  logic m_valid_q, m_valid_d, err_q, err_d;
  logic in_accum, accept, take, restart, add, latch;
  assign s_ready = ~m_valid_q | m_ready;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    moment_acc_ch #(.IN_W(IN_W), .ACC_W(ACC_W)) u_ch (
      .base_i(restart ? {ACC_W{1'b0}} : acc_q[g*ACC_W +: ACC_W]),
      .term_i(s_data[g*IN_W +: IN_W]),
      .sum_o (sum_w[g*ACC_W +: ACC_W]),
      .ovf_o (ovf_w[g])
    );
  end
  always_comb begin
    in_accum  = state_q == ACCUM;
    accept    = s_valid & s_ready & ce;
    take      = m_valid_q & m_ready & ce;
    restart   = accept & s_first;
    add       = accept & (s_first | in_accum);
    latch     = add & s_last;
    state_d   = add ? (s_last ? IDLE : ACCUM) : state_q;
    acc_d     = add ? sum_w : acc_q;
    ovf_d     = restart ? ovf_w : add ? (ovf_q | ovf_w) : ovf_q;
    cnt_d     = restart ? CNT_W'(1) : (add & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    m_data_d  = latch ? sum_w : m_data_q;
    m_ovf_d   = latch ? ovf_d : m_ovf_q;
    m_count_d = latch ? cnt_d : m_count_q;
    m_valid_d = latch | (m_valid_q & ~take);
    // A first flag while accumulating, or its absence while idle, is a framing error.
    err_d     = err_q | (accept & (s_first == in_accum));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_ovf_q   <= '0;
      m_count_q <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_ovf_q   <= m_ovf_d;
      m_count_q <= m_count_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_count = m_count_q;
  assign m_ovf   = m_ovf_q;
  assign err     = err_q;
endmodule

// File: tb/tb_moment_acc_multi.sv
// tb_moment_acc_multi: directed vector table plus hand sequences for moment_acc_multi at default parameters.
module tb_moment_acc_multi;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b1;
  logic s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic s_ready, m_valid, err;
  logic [114:0] s_data = '0;
  logic [144:0] m_data;
  logic [15:0] m_count;
  logic [4:0] m_ovf;
  int checks = 0, errors = 0;

  moment_acc_multi dut (
    .clk(clk), .rst(rst), .ce(ce), .s_valid(s_valid), .s_ready(s_ready),
    .s_first(s_first), .s_last(s_last), .s_data(s_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_count(m_count), .m_ovf(m_ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, f, l, mr;
    logic [22:0] d0, d1;
    logic ev;
    logic [28:0] e0, e1;
    logic [15:0] ec;
    logic esr, eerr;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input logic mr,
                       input logic [22:0] d0, input logic [22:0] d1);
    s_valid = v; s_first = f; s_last = l; m_ready = mr;
    s_data = {69'd0, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1,1,0,1, 23'd5,        23'd0,        0, 29'd0,   29'd0,          16'd0, 1, 0};
    vt[1]  = '{1,0,0,1, 23'h7FFFFE,   23'd0,        0, 29'd0,   29'd0,          16'd0, 1, 0};
    vt[2]  = '{1,0,1,1, 23'd7,        23'd0,        1, 29'd10,  29'd0,          16'd3, 1, 0};
    vt[3]  = '{0,0,0,1, 23'd0,        23'd0,        0, 29'd10,  29'd0,          16'd3, 1, 0};
    vt[4]  = '{1,1,1,0, 23'd0,        23'h7FFFFF,   1, 29'd0,   29'h1FFFFFFF,   16'd1, 0, 0};
    vt[5]  = '{0,0,0,0, 23'd0,        23'd0,        1, 29'd0,   29'h1FFFFFFF,   16'd1, 0, 0};
    vt[6]  = '{0,0,0,1, 23'd0,        23'd0,        0, 29'd0,   29'h1FFFFFFF,   16'd1, 1, 0};
    vt[7]  = '{1,1,1,0, 23'd3,        23'd0,        1, 29'd3,   29'd0,          16'd1, 0, 0};
    vt[8]  = '{1,1,0,0, 23'd100,      23'd0,        1, 29'd3,   29'd0,          16'd1, 0, 0};
    vt[9]  = '{1,1,0,0, 23'd100,      23'd0,        1, 29'd3,   29'd0,          16'd1, 0, 0};
    vt[10] = '{1,1,0,1, 23'd100,      23'd0,        0, 29'd3,   29'd0,          16'd1, 1, 0};
    vt[11] = '{1,0,1,1, 23'd1,        23'd0,        1, 29'd101, 29'd0,          16'd2, 1, 0};
    vt[12] = '{0,0,0,1, 23'd0,        23'd0,        0, 29'd101, 29'd0,          16'd2, 1, 0};

    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].v, vt[i].f, vt[i].l, vt[i].mr, vt[i].d0, vt[i].d1);
      tick();
      chk($sformatf("v%0d_m_valid", i), m_valid, vt[i].ev);
      chk($sformatf("v%0d_ch0", i), m_data[28:0], vt[i].e0);
      chk($sformatf("v%0d_ch1", i), m_data[57:29], vt[i].e1);
      chk($sformatf("v%0d_count", i), m_count, vt[i].ec);
      chk($sformatf("v%0d_s_ready", i), s_ready, vt[i].esr);
      chk($sformatf("v%0d_err", i), err, vt[i].eerr);
    end

    // 128 beats of the largest positive term: wraps or clamps depending on build
    for (int i = 0; i < 128; i++) begin
      drive(1, i == 0, i == 127, 1, 23'h3FFFFF, 23'd0);
      tick();
      if (i < 127) chk("big_not_valid", m_valid, 0);
    end
    drive(0, 0, 0, 0, 23'd0, 23'd0);
`ifdef MOMENT_ACC_SAT_EN
    chk("big_sum", m_data[28:0], 29'h0FFFFFFF);
    chk("big_ovf", m_ovf, 5'b00001);
`else
    chk("big_sum", m_data[28:0], 29'h1FFFFF80);
    chk("big_ovf", m_ovf, 5'b00000);
`endif
    chk("big_count", m_count, 16'd128);
    chk("big_valid", m_valid, 1);

    // take and new latch in the same cycle: new result wins, valid stays high
    drive(1, 1, 1, 1, 23'h7FFFFD, 23'd0);
    tick();
    chk("tl_valid", m_valid, 1);
    chk("tl_sum", m_data[28:0], 29'h1FFFFFFD);
    chk("tl_ovf", m_ovf, 5'b00000);
    chk("tl_count", m_count, 16'd1);
    drive(0, 0, 0, 1, 23'd0, 23'd0);
    tick();
    chk("tl_taken", m_valid, 0);

    // framing errors: stray beat in IDLE dropped, restart mid-cluster
    drive(1, 0, 0, 1, 23'd50, 23'd0);
    tick();
    chk("fe_drop_err", err, 1);
    chk("fe_drop_valid", m_valid, 0);
    drive(1, 1, 0, 1, 23'd20, 23'd0); tick();
    drive(1, 0, 0, 1, 23'd30, 23'd0); tick();
    drive(1, 1, 0, 1, 23'd4, 23'd0);  tick();
    drive(1, 0, 1, 1, 23'd6, 23'd0);  tick();
    drive(0, 0, 0, 1, 23'd0, 23'd0);
    chk("fe_sum", m_data[28:0], 29'd10);
    chk("fe_count", m_count, 16'd2);
    chk("fe_valid", m_valid, 1);
    chk("fe_err", err, 1);
    tick();

    // async reset mid-cluster, then clock-enable freeze
    drive(1, 1, 0, 1, 23'd9, 23'd0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_err", err, 0);
    chk("ar_data", m_data, 0);
    chk("ar_count", m_count, 0);
    chk("ar_valid", m_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    ce = 1'b0;
    drive(1, 1, 1, 1, 23'd77, 23'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ce0_valid", m_valid, 0);
      chk("ce0_count", m_count, 0);
    end
    drive(1, 0, 0, 1, 23'd5, 23'd0);
    tick();
    chk("ce0_err", err, 0);
    ce = 1'b1;
    drive(1, 1, 1, 1, 23'd77, 23'd0);
    tick();
    chk("ce1_sum", m_data[28:0], 29'd77);
    chk("ce1_count", m_count, 16'd1);
    chk("ce1_valid", m_valid, 1);
    ce = 1'b0;
    drive(0, 0, 0, 1, 23'd0, 23'd0);
    tick();
    tick();
    chk("ce0_hold_valid", m_valid, 1);
    chk("ce0_hold_sum", m_data[28:0], 29'd77);
    ce = 1'b1;
    tick();
    chk("ce1_take", m_valid, 0);

    // point counter saturates at all-ones
    for (int i = 0; i < 65537; i++) begin
      drive(1, i == 0, i == 65536, 1, 23'd1, 23'd0);
      tick();
    end
    drive(0, 0, 0, 1, 23'd0, 23'd0);
    chk("sat_count", m_count, 16'hFFFF);
    chk("sat_sum", m_data[28:0], 29'd65537);
    chk("sat_valid", m_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
